// File: rtl/lsu_mem_master_if.sv
// Bus bundle for the load/store unit: CPU request/response channel plus the
// word-organised data-memory channel. master = LSU side, slave = CPU/memory side.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_exc;
  logic [31:0] resp_pc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, req_pc, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_pc,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, req_pc, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_pc,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: checks alignment/range, issues a
// word-aligned memory access, and returns extended load data or an exception.
module lsu_mem_master #(
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input logic              clk,
  input logic              reset,
  lsu_mem_master_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [1:0] EXC_OK      = 2'b00;
  localparam logic [1:0] EXC_LOAD    = 2'b01;
  localparam logic [1:0] EXC_STORE   = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    op_q;
  logic          we_q;
  logic [1:0]    addr_lo_q;
  logic [31:0]   pc_q;
  logic [1:0]    exc_q;
  logic [31:0]   rdata_q;

  logic          legal;
  logic          align_ok;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [15:0]   half_c;
  logic [7:0]    byte_c;
  logic [31:0]   ext_c;

  assign bus.req_ready = (state == IDLE);

  // Request decode: byte enables, lane-replicated store data and legality.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    be_c     = 4'b0000;
    wdata_c  = 32'h0;
    align_ok = 1'b0;
    unique case (bus.req_op)
      3'b000: begin
        be_c     = 4'b1111;
        wdata_c  = bus.req_wdata;
        align_ok = (bus.req_addr[1:0] == 2'b00);
      end
      3'b001, 3'b011: begin
        be_c     = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{bus.req_wdata[15:0]}};
        align_ok = ~bus.req_addr[0];
      end
      3'b010, 3'b100: begin
        be_c     = 4'b0001 << bus.req_addr[1:0];
        wdata_c  = {4{bus.req_wdata[7:0]}};
        align_ok = 1'b1;
      end
      default: begin
        be_c     = 4'b0000;
        wdata_c  = 32'h0;
        align_ok = 1'b0;
      end
    endcase
    if (!bus.req_we) wdata_c = 32'h0;
    legal = align_ok && (bus.req_addr < ADDR_LIMIT);
  end

  // Load extraction from the acknowledged word using the latched op/lane.
  always_comb begin
    half_c = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    unique case (addr_lo_q)
      2'd0:    byte_c = bus.mem_rdata[7:0];
      2'd1:    byte_c = bus.mem_rdata[15:8];
      2'd2:    byte_c = bus.mem_rdata[23:16];
      default: byte_c = bus.mem_rdata[31:24];
    endcase
    unique case (op_q)
      3'b000:  ext_c = bus.mem_rdata;
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b011:  ext_c = {16'h0, half_c};
      3'b010:  ext_c = {{24{byte_c[7]}}, byte_c};
      3'b100:  ext_c = {24'h0, byte_c};
      default: ext_c = 32'h0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      op_q           <= 3'b000;
      we_q           <= 1'b0;
      addr_lo_q      <= 2'b00;
      pc_q           <= 32'h0;
      exc_q          <= EXC_OK;
      rdata_q        <= 32'h0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'h0;
      bus.mem_be     <= 4'b0000;
      bus.mem_wdata  <= 32'h0;
      bus.resp_valid <= 1'b0;
      bus.resp_exc   <= EXC_OK;
      bus.resp_rdata <= 32'h0;
      bus.resp_pc    <= 32'h0;
    end else begin
      bus.resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pc_q <= bus.req_pc;
            we_q <= bus.req_we;
            if (legal) begin
              op_q          <= bus.req_op;
              addr_lo_q     <= bus.req_addr[1:0];
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_be    <= be_c;
              bus.mem_wdata <= wdata_c;
              state         <= ISSUE;
            end else begin
              exc_q   <= bus.req_we ? EXC_STORE : EXC_LOAD;
              rdata_q <= 32'h0;
              state   <= DONE;
            end
          end
        end
        ISSUE: begin
          // An ack on the last allowed cycle is checked first, so it wins.
          if (bus.mem_ack) begin
            rdata_q     <= we_q ? 32'h0 : ext_c;
            exc_q       <= EXC_OK;
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.mem_be  <= 4'b0000;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(TIMEOUT - 1)) begin
              rdata_q     <= 32'h0;
              exc_q       <= EXC_TIMEOUT;
              bus.mem_req <= 1'b0;
              bus.mem_we  <= 1'b0;
              bus.mem_be  <= 4'b0000;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_exc   <= exc_q;
          bus.resp_rdata <= rdata_q;
          bus.resp_pc    <= pc_q;
          wait_cnt       <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized self-checking bench for lsu_mem_master against a size/offset
// arithmetic model of the load/store rules.
module tb_lsu_mem_master;

  localparam int unsigned TIMEOUT = 16;
  localparam logic [31:0] LIMIT   = 32'h0000_3000;

  logic clk;
  logic reset;
  lsu_mem_master_if bus ();

  lsu_mem_master #(.TIMEOUT(TIMEOUT), .ADDR_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          legal;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  // Access size in bytes, natural alignment, shifted enable mask, replicated data.
  function automatic exp_t model(input logic [2:0] op, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    int unsigned size;
    int unsigned off;
    longint unsigned mask;
    longint unsigned lane;
    case (op)
      3'd0:       size = 4;
      3'd1, 3'd3: size = 2;
      3'd2, 3'd4: size = 1;
      default:    size = 0;
    endcase
    off     = addr % 4;
    e.legal = (size != 0) && ((addr % size) == 0) && (addr < LIMIT);
    e.maddr = addr - off;
    e.be    = 4'b0000;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    if (e.legal) begin
      mask = (64'd1 << (8 * size)) - 1;
      e.be = 4'(((1 << size) - 1) << off);
      if (we) begin
        for (int k = 0; k < 4 / size; k++)
          e.wdata = e.wdata | 32'((longint'(wd) & mask) << (8 * size * k));
      end else begin
        lane = (longint'(rd) >> (8 * off)) & mask;
        if ((op == 3'd1 || op == 3'd2) && lane[8 * size - 1]) lane = lane | ~mask;
        e.rdata = 32'(lane);
      end
    end
    return e;
  endfunction

  // One complete transaction. ack_delay = index of the ISSUE cycle carrying
  // mem_ack (0 = first); values >= TIMEOUT mean the memory never answers.
  task automatic do_txn(input logic [2:0] op, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] pc,
                        input int ack_delay);
    exp_t        e;
    int          ncyc;
    logic [1:0]  exc;
    e    = model(op, we, addr, wd, rd);
    ncyc = (ack_delay < int'(TIMEOUT)) ? ack_delay + 1 : int'(TIMEOUT);
    if (!e.legal)                       exc = we ? 2'b10 : 2'b01;
    else if (ack_delay < int'(TIMEOUT)) exc = 2'b00;
    else                                exc = 2'b11;

    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_pc    = pc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom();
    bus.req_wdata = $urandom();
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);

    if (e.legal) begin
      for (int k = 0; k < ncyc; k++) begin
        check("mem_req",    32'(bus.mem_req), 32'd1);
        check("mem_we",     32'(bus.mem_we), 32'(we));
        check("mem_addr",   bus.mem_addr, e.maddr);
        check("mem_be",     32'(bus.mem_be), 32'(e.be));
        check("mem_wdata",  bus.mem_wdata, e.wdata);
        check("resp_early", 32'(bus.resp_valid), 32'd0);
        bus.mem_ack   = (k == ack_delay);
        bus.mem_rdata = (k == ack_delay) ? rd : $urandom();
        @(posedge clk); #1;
      end
      check("mem_req_drop", 32'(bus.mem_req), 32'd0);
      check("mem_be_drop",  32'(bus.mem_be), 32'd0);
    end else begin
      check("mem_req_illegal", 32'(bus.mem_req), 32'd0);
    end
    check("resp_not_yet", 32'(bus.resp_valid), 32'd0);
    // Stray ack while the response is pending must be ignored.
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom();
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_exc",   32'(bus.resp_exc), 32'(exc));
    check("resp_rdata", bus.resp_rdata, (exc == 2'b00) ? e.rdata : 32'h0);
    check("resp_pc",    bus.resp_pc, pc);
    check("mem_req_idle", 32'(bus.mem_req), 32'd0);
    @(posedge clk); #1;
    check("resp_pulse", 32'(bus.resp_valid), 32'd0);
    check("resp_hold",  32'(bus.resp_exc), 32'(exc));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_op    = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.req_pc    = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_mem_req",    32'(bus.mem_req), 32'd0);
    check("rst_mem_we",     32'(bus.mem_we), 32'd0);
    check("rst_mem_be",     32'(bus.mem_be), 32'd0);
    check("rst_mem_addr",   bus.mem_addr, 32'h0);
    check("rst_mem_wdata",  bus.mem_wdata, 32'h0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_exc",   32'(bus.resp_exc), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_pc",    bus.resp_pc, 32'h0);

    // Directed cases.
    do_txn(3'b000, 1'b0, 32'h10,   32'h0,         32'h8000_00F0, 32'h100, 0);
    do_txn(3'b010, 1'b0, 32'h23,   32'h0,         32'h9A12_3456, 32'h104, 0);
    do_txn(3'b100, 1'b0, 32'h23,   32'h0,         32'h9A12_3456, 32'h108, 1);
    do_txn(3'b001, 1'b1, 32'h0E,   32'h1234_BEEF, 32'h5555_AAAA, 32'h10C, 2);
    do_txn(3'b000, 1'b1, 32'h06,   32'hCAFE_F00D, 32'h0,         32'h110, 0);
    do_txn(3'b000, 1'b0, 32'h3000, 32'h0,         32'h0,         32'h114, 0);
    do_txn(3'b111, 1'b0, 32'h40,   32'h0,         32'h0,         32'h118, 0);
    do_txn(3'b011, 1'b0, 32'h2FFE, 32'h0,         32'h8765_4321, 32'h11C, 0);
    do_txn(3'b000, 1'b0, 32'h20,   32'h0,         32'h1111_2222, 32'h120, 1000);
    do_txn(3'b000, 1'b0, 32'h24,   32'h0,         32'h3333_4444, 32'h124, int'(TIMEOUT) - 1);
    do_txn(3'b010, 1'b1, 32'h2FFF, 32'h0000_00A5, 32'h0,         32'h128, int'(TIMEOUT));

    // Reset during ISSUE: drops mem_req at once, no response, later ack ignored.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'b000;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h80;
    bus.req_pc    = 32'h200;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_mem_req", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst_resp",      32'(bus.resp_valid), 32'd0);
    bus.mem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("late_ack_resp",    32'(bus.resp_valid), 32'd0);
      check("late_ack_mem_req", 32'(bus.mem_req), 32'd0);
    end
    bus.mem_ack = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      logic [2:0]  op;
      logic        we;
      logic [31:0] addr;
      int          dly;
      op   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      we   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? LIMIT + $urandom_range(0, 255)
                                         : 32'($urandom_range(0, 32'h2FFF));
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'd3;
      dly  = ($urandom_range(0, 3) == 3) ? int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1))
                                         : int'($urandom_range(0, 3));
      do_txn(op, we, addr, $urandom(), $urandom(), $urandom(), dly);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
